// File: rtl/mux_scan_pkg.sv
`default_nettype none
// mux_scan_pkg: mode encodings and the wrapped index increment shared by the scan selector.
// Revision 1.0
package mux_scan_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_MANUAL = 2'd0;
  localparam mode_t MODE_STEP   = 2'd1;
  localparam mode_t MODE_AUTO   = 2'd2;
  localparam mode_t MODE_HOLD   = 2'd3;

  // Wraps at n-1 rather than at the register width, so a non-power-of-two
  // input count never produces an out-of-range index.
  function automatic logic [31:0] next_idx(input logic [31:0] cur, input logic [31:0] n);
    return (cur >= n - 32'd1) ? 32'd0 : cur + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_tree_w.sv
`default_nettype none
// mux_tree_w: combinational NUM_IN-to-1 selector built as a balanced tree of 2:1 stages.
// Revision 1.0
module mux_tree_w
  import mux_scan_pkg::*;
#(
  parameter  int WIDTH  = 2,
  parameter  int NUM_IN = 5,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out
);

  function automatic int lvl_cnt(input int k);
    return (NUM_IN + (1 << k) - 1) >> k;
  endfunction

  logic [WIDTH-1:0] stage [NUM_IN];

  // Level k reduces lvl_cnt(k) words to lvl_cnt(k+1) using sel[k]; an odd
  // last word passes straight up. Stages are reduced in place: slot j is
  // only written after slots 2j and 2j+1 of the level below were read.
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      stage[i] = in_bus[i*WIDTH +: WIDTH];
    end
    for (int k = 0; k < SEL_W; k++) begin
      for (int j = 0; j < lvl_cnt(k + 1); j++) begin
        if (2*j + 1 < lvl_cnt(k)) begin
          stage[j] = sel[k] ? stage[2*j + 1] : stage[2*j];
        end else begin
          stage[j] = stage[2*j];
        end
      end
    end
    out = stage[0];
  end

endmodule
`default_nettype wire

// File: rtl/mux_scan_sel.sv
`default_nettype none
// mux_scan_sel: registered NUM_IN-to-1 word selector with manual, step, auto-scan and hold index control.
// Revision 1.0
module mux_scan_sel
  import mux_scan_pkg::*;
#(
  parameter  int WIDTH  = 2,
  parameter  int NUM_IN = 5,
  parameter  int DWELL  = 50_000_000,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  mode_t                   mode,
  input  logic [SEL_W-1:0]        sel_in,
  input  logic                    step,
  output logic [WIDTH-1:0]        out,
  output logic [SEL_W-1:0]        sel_cur,
  output logic                    sel_err
);

  localparam int               CNT_W      = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  mode_t            mode_q;
  logic             mode_chg;
  logic [SEL_W-1:0] sel_nxt, sel_inc;
  logic             err_nxt;
  logic [WIDTH-1:0] word;

  mux_tree_w #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_tree (
    .in_bus (in_bus),
    .sel    (sel_cur),
    .out    (word)
  );

  assign mode_chg = (mode != mode_q);
  assign sel_inc  = SEL_W'(next_idx(32'(sel_cur), 32'(NUM_IN)));

  always_comb begin
    sel_nxt = sel_cur;
    err_nxt = 1'b0;
    cnt_nxt = cnt;
    case (mode)
      MODE_MANUAL: begin
        if (32'(sel_in) < 32'(NUM_IN)) begin
          sel_nxt = sel_in;
        end else begin
          err_nxt = 1'b1;
        end
      end
      MODE_STEP: begin
        if (step) begin
          sel_nxt = sel_inc;
        end
      end
      MODE_AUTO: begin
        // Expiry is ignored on the entry cycle so a fresh dwell always runs in full.
        if (step || (cnt == '0 && !mode_chg)) begin
          sel_nxt = sel_inc;
          cnt_nxt = CNT_RELOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
      end
    endcase
    if (mode_chg) begin
      cnt_nxt = CNT_RELOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_cur <= '0;
      sel_err <= 1'b0;
      out     <= '0;
      cnt     <= CNT_RELOAD;
      mode_q  <= MODE_MANUAL;
    end else begin
      sel_cur <= sel_nxt;
      sel_err <= err_nxt;
      out     <= word;
      cnt     <= cnt_nxt;
      mode_q  <= mode;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_sel.sv
`default_nettype none
// tb_mux_scan_sel: vector table plus scoreboarded sequences for the scan selector.
// Revision 1.0
module tb_mux_scan_sel;
  import mux_scan_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  in_bus;
  mode_t       mode;
  logic [2:0]  sel_in;
  logic        step;
  logic [1:0]  out;
  logic [2:0]  sel_cur;
  logic        sel_err;
  logic [1:0]  out1;
  logic [1:0]  sel_cur1;
  logic        sel_err1;

  always #5 clk = ~clk;

  mux_scan_sel #(.WIDTH(2), .NUM_IN(5), .DWELL(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_bus  (in_bus),
    .mode    (mode),
    .sel_in  (sel_in),
    .step    (step),
    .out     (out),
    .sel_cur (sel_cur),
    .sel_err (sel_err)
  );

  // Power-of-two count with one-cycle dwell: wrap at the register width.
  mux_scan_sel #(.WIDTH(2), .NUM_IN(4), .DWELL(1)) dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_bus  (in_bus[7:0]),
    .mode    (mode),
    .sel_in  (sel_in[1:0]),
    .step    (step),
    .out     (out1),
    .sel_cur (sel_cur1),
    .sel_err (sel_err1)
  );

  typedef struct {
    logic [2:0] sel;
    logic       err;
    logic [1:0] out;
  } exp_t;

  typedef struct {
    logic [2:0] sel_in;
    logic       step;
    logic [2:0] exp_sel;
    logic       exp_err;
    logic [1:0] exp_out;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[10];
  int   total = 0;
  int   bad = 0;
  int   last_sel = 0;
  int   auto_exp[23] = '{3,3,3,3,4,4,0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,4};
  int   d1_main[5]   = '{1,1,1,1,2};
  int   d1_fast[5]   = '{1,2,3,0,1};
  int   rel_exp[5]   = '{0,0,0,0,1};

  function automatic logic [1:0] word(input logic [9:0] b, input int i);
    return b[i*2 +: 2];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic cyc(input mode_t m, input logic [2:0] si, input logic st,
                     input logic [2:0] es, input logic ee, input logic [1:0] eo,
                     input string name);
    exp_t e;
    exp_t g;
    mode   = m;
    sel_in = si;
    step   = st;
    e.sel  = es;
    e.err  = ee;
    e.out  = eo;
    exp_q.push_back(e);
    last_sel = int'(es);
    @(posedge clk);
    #1;
    step = 1'b0;
    g = exp_q.pop_front();
    chk({name, ".sel"}, 32'(sel_cur), 32'(g.sel));
    chk({name, ".err"}, 32'(sel_err), 32'(g.err));
    chk({name, ".out"}, 32'(out), 32'(g.out));
  endtask

  // out lags the index by one register, so it shows the word of the previous index.
  task automatic run(input mode_t m, input logic [2:0] si, input logic st,
                     input logic [2:0] es, input string name);
    cyc(m, si, st, es, 1'b0, word(in_bus, last_sel), name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{3'd3, 1'b0, 3'd3, 1'b0, 2'b01};
    tbl[1] = '{3'd3, 1'b0, 3'd3, 1'b0, 2'b10};
    tbl[2] = '{3'd6, 1'b0, 3'd3, 1'b1, 2'b10};
    tbl[3] = '{3'd7, 1'b1, 3'd3, 1'b1, 2'b10};
    tbl[4] = '{3'd5, 1'b0, 3'd3, 1'b1, 2'b10};
    tbl[5] = '{3'd1, 1'b0, 3'd1, 1'b0, 2'b10};
    tbl[6] = '{3'd4, 1'b0, 3'd4, 1'b0, 2'b11};
    tbl[7] = '{3'd2, 1'b0, 3'd2, 1'b0, 2'b11};
    tbl[8] = '{3'd0, 1'b1, 3'd0, 1'b0, 2'b00};
    tbl[9] = '{3'd0, 1'b0, 3'd0, 1'b0, 2'b01};

    rst_n  = 1'b0;
    mode   = MODE_MANUAL;
    sel_in = 3'd0;
    step   = 1'b0;
    in_bus = 10'b11_10_00_11_01;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.sel", 32'(sel_cur), 32'd0);
    chk("reset.out", 32'(out), 32'd0);
    chk("reset.err", 32'(sel_err), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cyc(MODE_MANUAL, tbl[i].sel_in, tbl[i].step, tbl[i].exp_sel, tbl[i].exp_err,
          tbl[i].exp_out, $sformatf("man%0d", i));
    end

    in_bus[1:0] = 2'b10;
    run(MODE_MANUAL, 3'd0, 1'b0, 3'd0, "bus_chg");
    run(MODE_MANUAL, 3'd3, 1'b0, 3'd3, "to3");
    cyc(MODE_MANUAL, 3'd7, 1'b0, 3'd3, 1'b1, word(in_bus, last_sel), "err7");

    run(MODE_STEP, 3'd7, 1'b0, 3'd3, "st_entry");
    run(MODE_STEP, 3'd7, 1'b1, 3'd4, "st4");
    run(MODE_STEP, 3'd0, 1'b0, 3'd4, "st_idle");
    run(MODE_STEP, 3'd0, 1'b1, 3'd0, "st_wrap");
    run(MODE_STEP, 3'd0, 1'b1, 3'd1, "st1");
    run(MODE_STEP, 3'd0, 1'b1, 3'd2, "st2");
    run(MODE_STEP, 3'd0, 1'b0, 3'd2, "st_idle2");
    run(MODE_STEP, 3'd0, 1'b1, 3'd3, "st3");

    for (int e = 0; e < 23; e++) begin
      run(MODE_AUTO, 3'd0, (e == 6 || e == 18), 3'(auto_exp[e]), $sformatf("auto%0d", e));
    end

    run(MODE_HOLD, 3'd0, 1'b0, 3'd4, "hold0");
    run(MODE_HOLD, 3'd0, 1'b1, 3'd4, "hold_step");
    in_bus[9:8] = 2'b00;
    run(MODE_HOLD, 3'd0, 1'b0, 3'd4, "hold_bus");
    repeat (3) run(MODE_HOLD, 3'd0, 1'b0, 3'd4, "hold");

    run(MODE_MANUAL, 3'd1, 1'b0, 3'd1, "pre_d1");
    chk("d1.pre_sel", 32'(sel_cur1), 32'd1);
    chk("d1.pre_err", 32'(sel_err1), 32'd0);
    for (int e = 0; e < 5; e++) begin
      run(MODE_AUTO, 3'd0, 1'b0, 3'(d1_main[e]), $sformatf("d1main%0d", e));
      chk($sformatf("d1fast%0d", e), 32'(sel_cur1), 32'(d1_fast[e]));
      if (e == 0) chk("d1.out", 32'(out1), 32'(word(in_bus, 1)));
    end

    run(MODE_AUTO, 3'd0, 1'b0, 3'd2, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async.sel", 32'(sel_cur), 32'd0);
    chk("async.out", 32'(out), 32'd0);
    chk("async.err", 32'(sel_err), 32'd0);
    chk("async.sel1", 32'(sel_cur1), 32'd0);
    @(posedge clk);
    #1;
    mode     = MODE_MANUAL;
    rst_n    = 1'b1;
    last_sel = 0;
    run(MODE_MANUAL, 3'd0, 1'b0, 3'd0, "rel0");
    for (int e = 0; e < 5; e++) begin
      run(MODE_AUTO, 3'd0, 1'b0, 3'(rel_exp[e]), $sformatf("rel_auto%0d", e));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_scan_sel.md
# mux_scan_sel

Parametrised, registered NUM_IN-to-1 selector of WIDTH-bit words, the next generation of the board-level lab multiplexers. The select index comes from one of four sources: direct switch select, single-step advance, timed auto-scan, or hold. The block sits between the switch/key inputs and the LED outputs. It drives the selected word plus the current index for display.

## Interface
- WIDTH, 2, bits per input word (≥1)
- NUM_IN, 5, number of input words (2..256)
- DWELL, 50_000_000, clock cycles per auto-scan position (≥1)
- SEL_W, $clog2(NUM_IN), derived localparam, not overridable
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_bus  in  NUM_IN*WIDTH  input words; word i = in_bus[i*WIDTH +: WIDTH]
- mode  in  2  0 MANUAL, 1 STEP, 2 AUTO, 3 HOLD
- sel_in  in  SEL_W  requested index in MANUAL
- step  in  1  single-cycle pulse, already debounced and edge-detected upstream
- out  out  WIDTH  registered selected word
- sel_cur  out  SEL_W  registered current index
- sel_err  out  1  registered; high while MANUAL requests sel_in ≥ NUM_IN

## Operation
- Reset (async assert, sync release): sel_cur=0, out=0, sel_err=0, dwell counter=DWELL-1, mode_q=MANUAL.
- MANUAL:
  - If sel_in<NUM_IN, sel_cur←sel_in and sel_err←0.
  - Otherwise sel_cur holds and sel_err←1.
  - step is ignored.
- STEP: each cycle with step=1 advances sel_cur by one, wrapping NUM_IN-1→0. sel_err←0.
- AUTO:
  - The dwell counter decrements every cycle.
  - At 0, sel_cur advances with wrap and the counter reloads DWELL-1.
  - step=1 forces an immediate advance and reloads the counter.
  - If step and expiry coincide, advance exactly once and reload.
  - sel_err←0.
- HOLD: sel_cur and the counter freeze. sel_err←0. out keeps tracking in_bus[sel_cur].
- Mode change: detected by comparing against registered mode_q. In the cycle mode≠mode_q, the counter reloads DWELL-1.
- Select logic: sel_cur must never hold a value ≥NUM_IN. Increment compares against NUM_IN-1, not 2^SEL_W-1.
- Data path: out←in_bus word sel_cur every cycle, in all modes.
- DWELL=1: AUTO advances every cycle.

## Timing
- in_bus change to out: 1 cycle.
- sel_in (MANUAL) or step to sel_cur: 1 cycle. sel_in or step to out: 2 cycles.
- AUTO: sel_cur changes every DWELL cycles exactly. The first advance comes DWELL cycles after entering AUTO or after reset release.
- sel_err is valid in the same cycle as the corresponding sel_cur update.
- Reset asserted mid-scan: all outputs go to reset values immediately, without waiting for a clock. Operation resumes from index 0 with a full dwell.

## Structure
- Shared package mux_scan_pkg holds:
  - mode encoding constants MODE_MANUAL/STEP/AUTO/HOLD;
  - a function next_idx(cur, n) giving the wrapped increment.
- Sub-module mux_tree_w: purely combinational, parametrised WIDTH/NUM_IN, built as a balanced tree of WIDTH-bit 2:1 mux stages.
  - Level k uses sel bit k.
  - An odd leftover word passes through to the next level.
  - For NUM_IN=5, the top stage is selected by sel[2], with word 4 on its "1" side.
- The top level holds the counter, the index register, mode_q and the output register.

## Test plan
- Reset release, MANUAL, sel_in=3, in_bus word3=2'b10 → cycle 1 sel_cur=3, cycle 2 out=2'b10, sel_err=0.
- MANUAL, sel_in=6 with NUM_IN=5, prior sel_cur=3 → sel_cur stays 3, sel_err=1; sel_in=1 → sel_err=0, sel_cur=1.
- STEP, five step pulses starting from sel_cur=3 → sequence 4,0,1,2,3; no step means no change.
- AUTO with DWELL=4 → sel_cur advances at cycles 4,8,12 after entry; step at cycle 6 → advance at 7, next at 11.
- AUTO with DWELL=4, step on the expiry cycle → single advance, counter reloaded; HOLD then freezes sel_cur, and changing in_bus still updates out after 1 cycle.
- rst_n pulsed low asynchronously mid-AUTO with sel_cur=2 → out=0 and sel_cur=0 before the next edge; after release, full DWELL elapses before the first advance.
